// File: rtl/bm_sample_ctrl.sv
// Box-Muller sequencer: credit-based issue into the fixed-latency datapath, result capture FIFO, valid/ready output.
// Optional macro BM_CTRL_STATS_EN adds the stall_cnt output counting credit-starved RUN cycles.
module bm_sample_ctrl #(
    parameter int N_RES = 32,
    parameter int LAT   = 3,
    parameter int DEPTH = 8,
    parameter int CNT_W = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       start,
    input  logic [CNT_W-1:0]           num_samples,
    input  logic                       stop,
    output logic                       gen_en,
    input  logic [N_RES-1:0]           pipe_cos,
    input  logic [N_RES-1:0]           pipe_sin,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic [N_RES-1:0]           m_cos,
    output logic [N_RES-1:0]           m_sin,
    output logic                       m_last,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(DEPTH+1)-1:0] fill
`ifdef BM_CTRL_STATS_EN
    ,
    output logic [31:0]                stall_cnt
`endif
);

    localparam int PTR_W  = $clog2(DEPTH);
    localparam int FILL_W = $clog2(DEPTH+1);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t             state, state_nx;
    logic [CNT_W-1:0]   remaining;
    logic               cont;
    logic [LAT-1:0]     vld_sr, last_sr;
    logic [N_RES-1:0]   mem_cos [DEPTH];
    logic [N_RES-1:0]   mem_sin [DEPTH];
    logic [DEPTH-1:0]   mem_last;
    logic [PTR_W-1:0]   wr_ptr, rd_ptr;
    logic               push, pop, gen_nx, issue_last, credit_ok, have_work;
    logic [31:0]        used;

    // The current issue is not yet in vld_sr, so it is counted explicitly; this cycle's pop is not.
    always_comb begin
        state_nx   = state;
        used       = 32'($countones(vld_sr)) + 32'(fill) + 32'(gen_en);
        credit_ok  = used < 32'(DEPTH);
        have_work  = cont || ((remaining - CNT_W'(gen_en)) != '0);
        gen_nx     = (state == RUN) && !stop && credit_ok && have_work;
        issue_last = gen_en && !cont && (remaining == CNT_W'(1));
        case (state)
            IDLE:    if (start) state_nx = RUN;
            RUN:     if (stop || issue_last) state_nx = DRAIN;
            DRAIN:   if ((vld_sr == '0) && (fill == '0)) state_nx = DONE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            gen_en    <= 1'b0;
            remaining <= '0;
            cont      <= 1'b0;
            vld_sr    <= '0;
            last_sr   <= '0;
        end else begin
            state   <= state_nx;
            gen_en  <= gen_nx;
            vld_sr  <= (vld_sr << 1) | LAT'(gen_en);
            last_sr <= (last_sr << 1) | LAT'(issue_last);
            if (state == IDLE && start) begin
                remaining <= num_samples;
                cont      <= (num_samples == '0);
            end else if (gen_en && !cont) begin
                remaining <= remaining - CNT_W'(1);
            end
        end
    end

    assign push    = vld_sr[LAT-1];
    assign pop     = m_valid && m_ready;
    assign m_valid = (fill != '0);
    assign m_cos   = m_valid ? mem_cos[rd_ptr] : '0;
    assign m_sin   = m_valid ? mem_sin[rd_ptr] : '0;
    assign m_last  = m_valid ? mem_last[rd_ptr] : 1'b0;
    assign busy    = (state != IDLE);
    assign done    = (state == DONE);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            fill   <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   fill <= fill + FILL_W'(1);
                2'b01:   fill <= fill - FILL_W'(1);
                default: fill <= fill;
            endcase
        end
    end

    // Storage needs no reset: nothing is visible until fill says so.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_cos[wr_ptr]  <= pipe_cos;
            mem_sin[wr_ptr]  <= pipe_sin;
            mem_last[wr_ptr] <= last_sr[LAT-1];
        end
    end

    overflow_chk: assert property (@(posedge clk) disable iff (rst)
        !(push && !pop && (fill == FILL_W'(DEPTH))));

`ifdef BM_CTRL_STATS_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt <= '0;
        end else if (state == IDLE && start) begin
            stall_cnt <= '0;
        end else if (state == RUN && !gen_en && !credit_ok && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end
`endif

endmodule
